// File: rtl/c6288_pkg.sv
// ============================================================================
//  Module      : c6288_pkg
//  Description : Shared types and constants for the c6288 divider block.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package c6288_pkg;

   localparam int C6288_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } div_state_t;

   // Pattern returned with out_err on overflow / zero divisor
   localparam logic [2*C6288_W-1:0] C6288_DIV_ERR_DATA = {(2*C6288_W){1'b1}};

endpackage : c6288_pkg

`default_nettype wire

// File: rtl/c6288_div_step.sv
// ============================================================================
//  Module      : c6288_div_step
//  Description : One combinational restoring-division step (rem/dvd shift).
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module c6288_div_step #(
   parameter int W = 16
) (
   input  logic [W-1:0] rem_i,
   input  logic [W-1:0] dvd_i,
   input  logic [W-1:0] div_i,
   output logic [W-1:0] rem_o,
   output logic [W-1:0] dvd_o
);

   logic [W:0] w_trial;
   logic       w_qbit;

   // The trial remainder is W+1 bits wide so the compare never wraps;
   // when it succeeds the difference always fits back into W bits.
   assign w_trial = {rem_i, dvd_i[W-1]};
   assign w_qbit  = (w_trial >= {1'b0, div_i});
   assign rem_o   = w_qbit ? (w_trial[W-1:0] - div_i) : w_trial[W-1:0];
   assign dvd_o   = {dvd_i[W-2:0], w_qbit};

endmodule : c6288_div_step

`default_nettype wire

// File: rtl/c6288_div.sv
// ============================================================================
//  Module      : c6288_div
//  Description : Sequential 2W/W unsigned restoring divider, ready/valid.
//                Optional early error exit selected by C6288_DIV_ERR_EN.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module c6288_div
   import c6288_pkg::*;
#(
   parameter int W = C6288_W
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [2*W-1:0] in_product,
   input  logic [W-1:0]   in_divisor,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] out_data,
   output logic           out_err
);

   localparam int              CNT_W     = (W > 1) ? $clog2(W) : 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(W - 1);

   div_state_t       state_q;
   logic [W-1:0]     rem_q;
   logic [W-1:0]     dvd_q;
   logic [W-1:0]     div_q;
   logic [W-1:0]     rem_d;
   logic [W-1:0]     dvd_d;
   logic [CNT_W-1:0] cnt_q;
   logic             in_ready_q;
   logic             out_valid_q;

   c6288_div_step #(
      .W (W)
   ) u_step (
      .rem_i (rem_q),
      .dvd_i (dvd_q),
      .div_i (div_q),
      .rem_o (rem_d),
      .dvd_o (dvd_d)
   );

`ifdef C6288_DIV_ERR_EN
   localparam logic [2*W-1:0] ERR_DATA = (2*W)'(C6288_DIV_ERR_DATA);
   logic err_q;
   assign out_err = err_q;
`else
   assign out_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rem_q       <= '0;
         dvd_q       <= '0;
         div_q       <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
`ifdef C6288_DIV_ERR_EN
         err_q       <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid && in_ready_q) begin
                  in_ready_q <= 1'b0;
                  div_q      <= in_divisor;
                  cnt_q      <= '0;
`ifdef C6288_DIV_ERR_EN
                  if ((in_divisor == '0) || (in_product[2*W-1:W] >= in_divisor)) begin
                     rem_q       <= ERR_DATA[2*W-1:W];
                     dvd_q       <= ERR_DATA[W-1:0];
                     err_q       <= 1'b1;
                     out_valid_q <= 1'b1;
                     state_q     <= DONE;
                  end else begin
                     rem_q   <= in_product[2*W-1:W];
                     dvd_q   <= in_product[W-1:0];
                     state_q <= BUSY;
                  end
`else
                  rem_q   <= in_product[2*W-1:W];
                  dvd_q   <= in_product[W-1:0];
                  state_q <= BUSY;
`endif
               end
            end
            BUSY: begin
               rem_q <= rem_d;
               dvd_q <= dvd_d;
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == LAST_STEP) begin
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               // Result registers are frozen here until the consumer takes them
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
`ifdef C6288_DIV_ERR_EN
                  err_q       <= 1'b0;
`endif
                  state_q     <= IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = {rem_q, dvd_q};

endmodule : c6288_div

`default_nettype wire

// File: tb/tb_c6288_div.sv
// ============================================================================
//  Module      : tb_c6288_div
//  Description : Self-checking bench for c6288_div (table, random, corners).
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_c6288_div;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_product;
   logic [15:0] in_divisor;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_err;

   int n_checks = 0;
   int n_pass   = 0;

   c6288_div #(.W(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_product (in_product),
      .in_divisor (in_divisor),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_err    (out_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] prod;
      logic [15:0] dvs;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference: plain integer division, valid whenever the quotient fits W bits
   function automatic logic [31:0] ref_div(input logic [31:0] p, input logic [15:0] d);
      logic [31:0] q;
      logic [31:0] r;
      q = p / {16'h0, d};
      r = p % {16'h0, d};
      return {r[15:0], q[15:0]};
   endfunction

   // Issue one request; report result and the number of negedges from accept to out_valid
   task automatic transact(input logic [31:0] p, input logic [15:0] d, input bit release_out,
                           output logic [31:0] data, output logic err, output int lat);
      int k;
      lat  = -1;
      data = 'x;
      err  = 1'bx;
      @(negedge clk);
      k = 0;
      while (!in_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      in_valid   = 1'b1;
      in_product = p;
      in_divisor = d;
      @(posedge clk);
      #1 in_valid = 1'b0;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk);
         if (out_valid) begin
            lat  = c;
            data = out_data;
            err  = out_err;
            break;
         end
      end
      if (release_out && lat > 0) begin
         out_ready = 1'b1;
         @(posedge clk);
         #1 out_ready = 1'b0;
      end
   endtask

   initial begin
      logic [31:0] data;
      logic        err;
      int          lat;
      logic [15:0] a, b;
      logic [31:0] p, exp_d;
      logic [31:0] bp[4];
      logic [15:0] bd[4];
      int          idx, got, last;
      bit          acc;

      vecs[0] = '{32'h0000_0064, 16'h0007, 32'h0002_000E};
      vecs[1] = '{32'hFFFE_0001, 16'hFFFF, 32'h0000_FFFF};
      vecs[2] = '{32'h0000_0010, 16'h0004, 32'h0000_0004};
      vecs[3] = '{32'h0000_FFFF, 16'h0001, 32'h0000_FFFF};
      vecs[4] = '{32'h0000_0005, 16'h0009, 32'h0005_0000};
      vecs[5] = '{32'h0008_0000, 16'h0010, 32'h0000_8000};
      vecs[6] = '{32'hFFFE_FFFF, 16'hFFFF, 32'hFFFE_FFFF};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_product = '0; in_divisor = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_in_ready", in_ready, 1);
      check("reset_out_valid", out_valid, 0);
      check("reset_out_data", out_data, 0);
      check("reset_out_err", out_err, 0);

      // Table-driven vectors, including exact max and max-remainder cases
      for (int i = 0; i < 7; i++) begin
         transact(vecs[i].prod, vecs[i].dvs, 1'b1, data, err, lat);
         check($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
         check($sformatf("vec%0d_err", i), err, 0);
         check($sformatf("vec%0d_lat", i), lat, 17);
      end

      // Random multiplier round trips: (A*B)/B -> quotient A, remainder 0
      for (int i = 0; i < 30; i++) begin
         a = 16'($urandom);
         b = 16'($urandom_range(1, 65535));
         p = {16'h0, a} * {16'h0, b};
         transact(p, b, 1'b1, data, err, lat);
         check("roundtrip", data, {16'h0, a});
      end

      // Random non-overflowing divides against the reference model
      for (int i = 0; i < 20; i++) begin
         b = 16'($urandom_range(1, 65535));
         a = 16'($urandom % {16'h0, b});
         p = {a, 16'($urandom)};
         transact(p, b, 1'b1, data, err, lat);
         check("rand_div", data, ref_div(p, b));
      end

      // Overflow and zero divisor
`ifdef C6288_DIV_ERR_EN
      transact(32'h0001_0000, 16'h0001, 1'b1, data, err, lat);
      check("ovf_err", err, 1);
      check("ovf_data", data, 32'hFFFF_FFFF);
      check("ovf_lat", lat, 1);
      transact(32'h0000_1234, 16'h0000, 1'b1, data, err, lat);
      check("dz_err", err, 1);
      check("dz_data", data, 32'hFFFF_FFFF);
      check("dz_lat", lat, 1);
      transact(32'h0000_0064, 16'h0007, 1'b1, data, err, lat);
      check("post_err_data", data, 32'h0002_000E);
      check("post_err_err", err, 0);
`else
      transact(32'h0001_0000, 16'h0001, 1'b1, data, err, lat);
      check("ovf_noerr_err", err, 0);
      check("ovf_noerr_lat", lat, 17);
      transact(32'h0000_1234, 16'h0000, 1'b1, data, err, lat);
      check("dz_noerr_err", err, 0);
      check("dz_noerr_lat", lat, 17);
`endif

      // Backpressure: result must stay frozen while out_ready is low
      transact(32'h0000_0064, 16'h0007, 1'b0, data, err, lat);
      check("bp_first", data, 32'h0002_000E);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_valid", out_valid, 1);
         check("bp_data", out_data, 32'h0002_000E);
         check("bp_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      check("bp_rel_valid", out_valid, 0);
      check("bp_rel_in_ready", in_ready, 1);

      // Reset in the middle of BUSY
      in_valid = 1'b1; in_product = 32'h1234_5678; in_divisor = 16'hABCD;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (8) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_mid_valid", out_valid, 0);
      check("rst_mid_in_ready", in_ready, 1);
      check("rst_mid_data", out_data, 0);
      transact(32'h0000_0010, 16'h0004, 1'b1, data, err, lat);
      check("rst_after_data", data, 32'h0000_0004);
      check("rst_after_lat", lat, 17);

      // Back-to-back with in_valid and out_ready held high
      for (int i = 0; i < 4; i++) begin
         a = 16'($urandom);
         b = 16'($urandom_range(1, 65535));
         bp[i] = {16'h0, a} * {16'h0, b};
         bd[i] = b;
      end
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1;
      in_product = bp[0]; in_divisor = bd[0];
      idx = 0; got = 0; last = 0;
      for (int cyc = 0; cyc < 200 && got < 4; cyc++) begin
         acc = in_valid && in_ready;
         @(negedge clk);
         if (acc) begin
            idx++;
            if (idx < 4) begin
               in_product = bp[idx];
               in_divisor = bd[idx];
            end else begin
               in_valid = 1'b0;
            end
         end
         if (out_valid) begin
            exp_d = ref_div(bp[got], bd[got]);
            check("b2b_data", out_data, exp_d);
            check("b2b_rdy_overlap", in_ready, 0);
            if (got > 0) check("b2b_interval", cyc - last, 18);
            last = cyc;
            got++;
         end
      end
      check("b2b_count", got, 4);
      in_valid = 1'b0;
      @(negedge clk);
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("b2b_no_extra", out_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_c6288_div

`default_nettype wire

// File: doc/c6288_div.md
# c6288_div

Sequential 32/16 unsigned restoring divider forming the inverse path of the 16x16 c6288 multiplier test circuit. It takes a 32-bit product and a 16-bit operand and recovers the other 16-bit operand plus remainder. Results use the same packed 32-bit convention as the multiplier harness output, so product/operand round trips can be checked in one bench. It sits beside the multiplier harness in the iscas85 test tree as a ready/valid streaming block.

## Interface
- `W`, 16: operand width; product width is 2*W.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  block can accept a request.
- `in_product`  in  2W  dividend (multiplier product).
- `in_divisor`  in  W  divisor (one multiplier operand).
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `out_data`  out  2W  {remainder[W-1:0], quotient[W-1:0]}.
- `out_err`  out  1  overflow or divide-by-zero (macro-dependent, see Configuration).

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`, latch `rem`=product[2W-1:W], `dvd`=product[W-1:0], `div`=divisor, `cnt`=0, and go to BUSY.
- BUSY, one restoring step per clock:
  - t = {rem, dvd[W-1]} (W+1 bits).
  - If t >= {0,div}: rem = t-div, qbit = 1; else rem = t[W-1:0], qbit = 0.
  - dvd = {dvd[W-2:0], qbit}, so the quotient accumulates in `dvd`.
  - After step W (`cnt`==W-1), go to DONE.
- DONE:
  - `out_valid`=1, `out_data`={rem, dvd}.
  - Hold `out_data` stable until `out_valid`&&`out_ready`, then go to IDLE.
- `in_ready`=0 in BUSY and DONE. A request presented then is ignored and the upstream must hold it.
- All arithmetic is unsigned. The comparison uses W+1 bits, so there is no wrap.
- Exact round trip: for any A and B with B != 0, product A*B with divisor B returns quotient A, remainder 0.

## Timing
- Reset values: state=IDLE, `in_ready`=1 on the first cycle after reset, `out_valid`=0, `out_data`=0, `out_err`=0, internal registers 0.
- Reset during BUSY or DONE aborts the operation. No result is emitted, and the next cycle is IDLE.
- Latency: the accept edge is T. `out_valid` is high in the cycle after edge T+W (W+1 edges including accept).
- Throughput: one request per W+2 cycles when `out_ready` is held at 1.
- Back-to-back requests:
  - The handshake edge on the output moves the block to IDLE.
  - A new request is accepted at the earliest on the following edge.
  - `in_ready` never rises in the same cycle as `out_valid`.
- `out_ready` high while `out_valid`=0 has no effect.

## Configuration
- `C6288_DIV_ERR_EN` defined:
  - At accept, if divisor==0 or product[2W-1:W] >= divisor, skip BUSY and go directly to DONE on the accept edge.
  - The result is `out_err`=1 with `out_data`=32'hFFFF_FFFF, and `out_valid` is high in the cycle after accept.
  - Otherwise `out_err`=0.
- Undefined:
  - `out_err` is tied to 0.
  - Every request runs W steps.
  - Results for overflow or zero divisor are unspecified but deterministic. The block must not hang.

## Structure
- Shared package `c6288_pkg` holds:
  - state enum `div_state_t` (IDLE, BUSY, DONE);
  - `C6288_W`=16;
  - the error pattern constant `C6288_DIV_ERR_DATA`.
- One natural sub-module, `c6288_div_step`: a combinational single restoring step.
  - Inputs: rem, dvd, div.
  - Outputs: next rem, next dvd.
  - It is instantiated once and reused each BUSY cycle.

## Test plan
- Basic divide: product 32'h0000_0064, divisor 16'h0007 → `out_data`=32'h0002_000E, `out_err`=0. `out_valid` is high exactly in the cycle after edge T+16.
- Maximum exact case: product 32'hFFFE_0001, divisor 16'hFFFF → `out_data`=32'h0000_FFFF. Also random A,B≠0 round trips against the c6288 model: quotient A, remainder 0.
- Overflow and zero divisor, with `C6288_DIV_ERR_EN`:
  - product 32'h0001_0000, divisor 16'h0001 → `out_err`=1, `out_data`=32'hFFFF_FFFF, one cycle after accept.
  - Divisor 0 → same response.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE → `out_data` and `out_valid` stable and `in_ready`=0 throughout. Release `out_ready` → IDLE next cycle.
- Reset mid-operation: assert `rst_n`=0 at step 8 of BUSY → next cycle `out_valid`=0 and `in_ready`=1. A new request (product 32'h0000_0010, divisor 16'h0004) then yields 32'h0000_0004.
- Back-to-back with `out_ready`=1 and `in_valid` held high → requests complete every 18 cycles, with no dropped or duplicated results.
